rgmii_to_gmii_rx: RTL and testbench
===================================

Name: rgmii_to_gmii_rx

Overview:
- Receive-side PHY adapter. Converts the 4-bit double-data-rate RGMII receive bus from the PHY into an 8-bit single-data-rate GMII receive bus for the MAC receiver.
- Sits between the RGMII pins and the MAC's Rx_clk/Rxd/Rx_dv/Rx_er inputs.
- Forwards the receive clock to the MAC.
- Optionally decodes RGMII in-band link status sent between frames.

Parameters:
- NIBBLE_SWAP, default 0. 0: rising-edge nibble goes to RxD[3:0] (RGMII standard). 1: rising-edge nibble goes to RxD[7:4].

Ports:
- RGMII_RxClk, input, 1. Single clock, 125 MHz from the PHY. Both edges are used for capture.
- rst, input, 1. Reset, synchronous, active-high.
- RGMII_RxD, input, 4. DDR data nibble.
- RGMII_RxCtl, input, 1. DDR control: RX_DV on the rising edge, RX_DV xor RX_ER on the falling edge.
- ClkEN, input, 1. Output-stage enable; 1 = normal operation.
- RxD, output, 8. GMII data.
- RxDV, output, 1. GMII data valid.
- RxER, output, 1. GMII receive error.
- RxClk, output, 1. Equal to RGMII_RxClk, combinational pass-through.

Behaviour:
- Rising edge of RGMII_RxClk: register lo_q <= RGMII_RxD and ctl_r_q <= RGMII_RxCtl.
- Falling edge of RGMII_RxClk: register hi_q <= RGMII_RxD and ctl_f_q <= RGMII_RxCtl.
- Output stage, rising edge, when ClkEN=1:
  - RxD <= {hi_q, lo_q}, or {lo_q, hi_q} if NIBBLE_SWAP=1.
  - RxDV <= ctl_r_q.
  - RxER <= ctl_r_q ^ ctl_f_q.
- Output stage when ClkEN=0: RxD, RxDV and RxER hold their values. The capture registers keep running.
- Latency:
  - The byte whose low nibble is sampled at rising edge n and high nibble at the following falling edge appears on the outputs after rising edge n+1. Fixed latency of 1 cycle.
  - Back-to-back bytes stream at one byte per cycle with no bubbles.
- Control decode, by (RxDV, RxER):
  - (1,0): data.
  - (1,1): data error.
  - (0,1): carrier extension or false carrier; data passed through unmodified.
  - (0,0): idle or in-band status.
- Reset:
  - rst is sampled on rising edges.
  - While rst=1, every rising-edge register (lo_q, ctl_r_q, RxD, RxDV, RxER) loads 0.
  - Falling-edge registers (hi_q, ctl_f_q) load 0 on any falling edge where rst=1.
  - Reset overrides ClkEN.
  - First valid output is on the second rising edge after rst deasserts.
  - Reset asserted mid-frame truncates the frame: RxDV=0 from the next rising edge. No partial byte is emitted after that.
- The block makes no attempt to check frame integrity; the MAC handles it.

Optional Feature:
- Macro RGMII2GMII_INBAND_STATUS_EN.
- When defined, add three outputs: link_up (1), link_speed (2), link_duplex (1).
- Decode source: registered RxD[3:0], on cycles with RxDV=0, RxER=0 and ClkEN=1.
  - bit0 = link.
  - bits[2:1] = speed: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = reserved (ignored, no update).
  - bit3 = full duplex.
- Status outputs update only when the same nibble is decoded on two consecutive qualifying cycles (glitch filter).
- Status outputs reset to 0 and hold during frames.
- When the macro is undefined, these ports and their logic are absent.

Decomposition:
- Shared package rgmii_pkg holds the speed code constants (SPEED_10=2'b00, SPEED_100=2'b01, SPEED_1000=2'b10) and the status bit indices.
- One natural sub-module, rgmii_ddr_in: parameterised-width DDR input capture cell with rising/falling outputs and synchronous clear. It is instantiated once for the 5-bit bundle {RxCtl, RxD}.

Test Plan:
- Reset: hold rst=1 for 4 cycles while driving RGMII_RxD=4'hF and RGMII_RxCtl=1 -> RxD=8'h00, RxDV=0, RxER=0 throughout. First valid byte appears 2 rising edges after release.
- Frame: drive 0x55 x7, 0xD5, then 0x01..0x40 (rise nibble = low nibble, RxCtl=1 on both edges) -> identical byte stream on RxD with RxDV=1, RxER=0, 1-cycle latency, no gaps. RxDV drops one cycle after RxCtl goes low.
- Error: mid-frame byte 0xAB sent with RxCtl=1 on rise, 0 on fall -> RxD=8'hAB, RxDV=1, RxER=1 for exactly that cycle.
- ClkEN: deassert ClkEN for 3 cycles mid-frame -> outputs frozen at the last byte; streaming resumes with the current capture on reassertion.
- NIBBLE_SWAP=1: send byte 0x3C -> RxD=8'hC3.
- With RGMII2GMII_INBAND_STATUS_EN defined: idle nibble 4'hD held on both edges with RxCtl=0 for 2+ cycles -> link_up=1, link_speed=2'b10, link_duplex=1. A single-cycle 4'h0 glitch produces no change.

Source files
------------

// File: rtl/rgmii_pkg.sv
// rgmii_pkg: speed codes and in-band status nibble bit positions shared by the RGMII receive adapter
package rgmii_pkg;
  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
  localparam logic [1:0] SPEED_RSVD = 2'b11;
  localparam int ST_LINK     = 0;
  localparam int ST_SPEED_LO = 1;
  localparam int ST_SPEED_HI = 2;
  localparam int ST_DUPLEX   = 3;
endpackage

// File: rtl/rgmii_ddr_in.sv
// rgmii_ddr_in: W-bit DDR capture cell; ports clk, rst (sync, high, sampled on each edge), d in, q_r rising-edge sample, q_f falling-edge sample
module rgmii_ddr_in #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q_r,
  output logic [W-1:0] q_f
);
  always_ff @(posedge clk) q_r <= rst ? '0 : d;
  always_ff @(negedge clk) q_f <= rst ? '0 : d;
endmodule

// File: rtl/rgmii_to_gmii_rx.sv
// rgmii_to_gmii_rx: RGMII DDR rx to GMII SDR rx (RGMII_RxClk/RxD/RxCtl in, ClkEN output-stage enable, rst sync high; RxD/RxDV/RxER/RxClk out; link_up/link_speed/link_duplex only with RGMII2GMII_INBAND_STATUS_EN)
module rgmii_to_gmii_rx
  import rgmii_pkg::*;
#(
  parameter bit NIBBLE_SWAP = 1'b0
) (
  input  logic       RGMII_RxClk,
  input  logic       rst,
  input  logic [3:0] RGMII_RxD,
  input  logic       RGMII_RxCtl,
  input  logic       ClkEN,
  output logic [7:0] RxD,
  output logic       RxDV,
  output logic       RxER,
`ifdef RGMII2GMII_INBAND_STATUS_EN
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_duplex,
`endif
  output logic       RxClk
);
  logic [4:0] cap_r, cap_f;
  logic [3:0] lo_q, hi_q;
  logic       ctl_r_q, ctl_f_q;
  rgmii_ddr_in #(.W(5)) u_ddr (
    .clk (RGMII_RxClk),
    .rst (rst),
    .d   ({RGMII_RxCtl, RGMII_RxD}),
    .q_r (cap_r),
    .q_f (cap_f)
  );
  assign {ctl_r_q, lo_q} = cap_r;
  assign {ctl_f_q, hi_q} = cap_f;
  assign RxClk = RGMII_RxClk;
  always_ff @(posedge RGMII_RxClk)
    if (rst) begin
      RxD  <= '0;
      RxDV <= 1'b0;
      RxER <= 1'b0;
    end else if (ClkEN) begin
      RxD  <= NIBBLE_SWAP ? {lo_q, hi_q} : {hi_q, lo_q};
      RxDV <= ctl_r_q;
      RxER <= ctl_r_q ^ ctl_f_q;
    end
`ifdef RGMII2GMII_INBAND_STATUS_EN
  logic [3:0] prev_nib;
  logic       prev_ok;
  logic       qual;
  assign qual = ClkEN & ~RxDV & ~RxER;
  always_ff @(posedge RGMII_RxClk)
    if (rst) begin
      prev_nib    <= '0;
      prev_ok     <= 1'b0;
      link_up     <= 1'b0;
      link_speed  <= SPEED_10;
      link_duplex <= 1'b0;
    end else if (qual) begin
      prev_nib <= RxD[3:0];
      prev_ok  <= 1'b1;
      if (prev_ok && prev_nib == RxD[3:0] && RxD[ST_SPEED_HI:ST_SPEED_LO] != SPEED_RSVD) begin
        link_up     <= RxD[ST_LINK];
        link_speed  <= RxD[ST_SPEED_HI:ST_SPEED_LO];
        link_duplex <= RxD[ST_DUPLEX];
      end
    end else
      prev_ok <= 1'b0;
`endif
endmodule

// File: tb/tb_rgmii_to_gmii_rx.sv
// tb_rgmii_to_gmii_rx: scoreboard bench for rgmii_to_gmii_rx (standard and nibble-swapped instances)
module tb_rgmii_to_gmii_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] RGMII_RxD = 4'hF;
  logic       RGMII_RxCtl = 1'b1;
  logic       ClkEN = 1'b1;
  logic [7:0] RxD, RxD_s;
  logic       RxDV, RxER, RxClk, RxDV_s, RxER_s, RxClk_s;
`ifdef RGMII2GMII_INBAND_STATUS_EN
  logic       link_up, link_duplex, link_up_s, link_duplex_s;
  logic [1:0] link_speed, link_speed_s;
`endif
  always #4 clk = ~clk;
  rgmii_to_gmii_rx #(.NIBBLE_SWAP(1'b0)) dut (
    .RGMII_RxClk (clk),
    .rst         (rst),
    .RGMII_RxD   (RGMII_RxD),
    .RGMII_RxCtl (RGMII_RxCtl),
    .ClkEN       (ClkEN),
    .RxD         (RxD),
    .RxDV        (RxDV),
    .RxER        (RxER),
`ifdef RGMII2GMII_INBAND_STATUS_EN
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex),
`endif
    .RxClk       (RxClk)
  );
  rgmii_to_gmii_rx #(.NIBBLE_SWAP(1'b1)) dut_s (
    .RGMII_RxClk (clk),
    .rst         (rst),
    .RGMII_RxD   (RGMII_RxD),
    .RGMII_RxCtl (RGMII_RxCtl),
    .ClkEN       (ClkEN),
    .RxD         (RxD_s),
    .RxDV        (RxDV_s),
    .RxER        (RxER_s),
`ifdef RGMII2GMII_INBAND_STATUS_EN
    .link_up     (link_up_s),
    .link_speed  (link_speed_s),
    .link_duplex (link_duplex_s),
`endif
    .RxClk       (RxClk_s)
  );
  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       dv;
    logic       er;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] pend_d = '0, out_d = '0;
  logic       pend_dv = 1'b0, pend_er = 1'b0, out_dv = 1'b0, out_er = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic cr, input logic cf, input logic en);
    @(negedge clk);
    #1;
    rst = 1'b0;
    ClkEN = en;
    RGMII_RxD = d[3:0];
    RGMII_RxCtl = cr;
    if (en) begin
      out_d = pend_d;
      out_dv = pend_dv;
      out_er = pend_er;
    end
    if (out_dv || out_er) q.push_back('{cyc + 1, out_d, out_dv, out_er});
    pend_d = d;
    pend_dv = cr;
    pend_er = cr ^ cf;
    @(posedge clk);
    #1;
    RGMII_RxD = d[7:4];
    RGMII_RxCtl = cf;
  endtask
  task automatic rst_cycle(input logic en);
    @(negedge clk);
    #1;
    rst = 1'b1;
    ClkEN = en;
    RGMII_RxD = 4'hF;
    RGMII_RxCtl = 1'b1;
    {out_d, out_dv, out_er, pend_d, pend_dv, pend_er} = '0;
    @(posedge clk);
    #1;
    chk("reset_rxd", RxD, 8'h00);
    chk("reset_rxdv", RxDV, 1'b0);
    chk("reset_rxer", RxER, 1'b0);
  endtask
  always @(negedge clk)
    if (RxDV === 1'b1 || RxER === 1'b1) begin
      if (q.size() == 0)
        chk("unexpected_output", {RxD, RxDV, RxER}, 10'h0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("rxd", RxD, e.d);
        chk("rxdv", RxDV, e.dv);
        chk("rxer", RxER, e.er);
        chk("rxd_swapped", RxD_s, {e.d[3:0], e.d[7:4]});
        chk("rxclk_pass", RxClk, clk);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d entries pending", q.size());
    $fatal(1, "watchdog");
  end
  initial begin
    rst_cycle(1'b1);
    rst_cycle(1'b0);
    rst_cycle(1'b1);
    rst_cycle(1'b0);
    repeat (2) send(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (7) send(8'h55, 1'b1, 1'b1, 1'b1);
    send(8'hD5, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 8'h40; i++) begin
      send(8'(i), 1'b1, 1'b1, !(i inside {[33:35]}));
      if (i == 16) send(8'hAB, 1'b1, 1'b0, 1'b1);
    end
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (2) send(8'h00, 1'b0, 1'b0, 1'b1);
    send(8'h0F, 1'b0, 1'b1, 1'b1);
    repeat (3) send(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) send(8'h55, 1'b1, 1'b1, 1'b1);
    rst_cycle(1'b1);
    rst_cycle(1'b1);
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    send(8'h5A, 1'b1, 1'b1, 1'b1);
    repeat (3) send(8'h00, 1'b0, 1'b0, 1'b1);
`ifdef RGMII2GMII_INBAND_STATUS_EN
    chk("status_link_idle0", link_up, 1'b0);
    repeat (5) send(8'hDD, 1'b0, 1'b0, 1'b1);
    chk("status_link_up", link_up, 1'b1);
    chk("status_speed", link_speed, 2'b10);
    chk("status_duplex", link_duplex, 1'b1);
    send(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (4) begin
      send(8'hDD, 1'b0, 1'b0, 1'b1);
      chk("glitch_link", link_up, 1'b1);
      chk("glitch_speed", link_speed, 2'b10);
      chk("glitch_duplex", link_duplex, 1'b1);
    end
`endif
    repeat (4) send(8'h00, 1'b0, 1'b0, 1'b1);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
